piso_stream_sched: RTL and testbench

- Round-robin scheduler that shares one piso_streamer write port among NREQ 32-bit word producers (e.g. header writer, entropy coder, marker inserter).
- The streamer has no backpressure; it drains one word per 4 cycles. This block keeps an exact shadow occupancy model and grants a write only when a slot is guaranteed.
- Sits between the JPEG producers and the streamer's din/din_valid inputs.
- Provides packet locking, a flush handshake and a sticky overflow flag.

---
 rtl/piso_stream_sched.sv | 248 ++++++++++++++++++++++++
 tb/tb_piso_stream_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_stream_sched.sv
// piso_stream_sched
//   Round-robin scheduler sharing one piso_streamer write port among NREQ
//   32-bit word producers. The streamer has no backpressure and drains one
//   word every 4 cycles, so this block keeps an exact shadow of the
//   streamer's occupancy and only grants a write when a slot is guaranteed.
//   Multi-word packets lock the grant onto one requester until its last word.
//   A flush request stops new grants and waits for the shadow FIFO to drain.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_data          NREQ x 32-bit words, requester i at [32i+31:32i]
//   req_valid         per-requester word valid
//   req_last          per-requester end-of-packet marker
//   req_ready         per-requester accept (combinational, one-hot or zero)
//   out_din           registered word to streamer din
//   out_din_valid     registered write strobe to streamer din_valid
//   strm_full         streamer full flag (sets overflow_err)
//   flush_req         one-cycle pulse: stop granting and wait for drain
//   flush_done        one-cycle pulse: shadow occupancy reached zero
//   occ               shadow occupancy in words (DEPTH_PWR+1 bits)
//   overflow_err      sticky error, cleared only by rst
//
// Optional feature (macro PISO_STREAM_SCHED_BYTE_CNT_EN):
//   byte_cnt          bytes written since reset / last flush_done
//   last_frame_bytes  byte_cnt captured at flush_done

module piso_stream_sched #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned DEPTH_PWR = 4,
  parameter int unsigned HEADROOM  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ*32-1:0]   req_data,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          out_din,
  output logic                 out_din_valid,
  input  logic                 strm_full,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic [DEPTH_PWR:0]   occ,
  output logic                 overflow_err
`ifdef PISO_STREAM_SCHED_BYTE_CNT_EN
  ,
  output logic [31:0]          byte_cnt,
  output logic [31:0]          last_frame_bytes
`endif
);

  localparam int unsigned RW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [RW-1:0]      LAST_IDX  = RW'(NREQ - 1);
  localparam logic [DEPTH_PWR:0] OCC_LIMIT = (DEPTH_PWR+1)'((1 << DEPTH_PWR) - HEADROOM);
  localparam logic [DEPTH_PWR:0] OCC_FULL  = (DEPTH_PWR+1)'(1 << DEPTH_PWR);

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_XFER  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Sequential state
  logic [1:0]           state_q, state_d;
  logic [RW-1:0]        rr_q, rr_d;
  logic [RW-1:0]        lock_q, lock_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [DEPTH_PWR:0]   occ_q, occ_d;
  logic [1:0]           dcnt_q, dcnt_d;
  logic [31:0]          dout_q, dout_d;
  logic                 dvld_q, dvld_d;
  logic                 ovf_q, ovf_d;

  // Combinational helpers
  logic [DEPTH_PWR:0]   occ_pend;
  logic                 slot_ok;
  logic                 drain;
  logic [RW-1:0]        cand;
  logic                 arb_hit;
  logic [RW-1:0]        arb_idx;
  logic                 acc;
  logic [31:0]          acc_data;
  logic                 acc_last;
  logic                 flush_done_c;

  function automatic logic [RW-1:0] wrap_inc(input logic [RW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  // The registered word is not yet in the shadow FIFO, so count it here.
  assign occ_pend = occ_q + {{DEPTH_PWR{1'b0}}, dvld_q};
  assign slot_ok  = (occ_pend < OCC_LIMIT);

  // Cyclic search for the first valid requester at or after rr_q.
  always_comb begin
    cand    = rr_q;
    arb_hit = 1'b0;
    arb_idx = rr_q;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!arb_hit && req_valid[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  // Grant generation: at most one ready bit, and only with a guaranteed slot.
  always_comb begin
    req_ready = '0;
    case (state_q)
      ST_ARB: begin
        if (slot_ok && !flush_req && !flush_pend_q && arb_hit) begin
          req_ready[arb_idx] = 1'b1;
        end
      end
      ST_XFER: begin
        if (slot_ok && req_valid[lock_q]) begin
          req_ready[lock_q] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Accepted word mux
  always_comb begin
    acc      = |(req_ready & req_valid);
    acc_data = '0;
    acc_last = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        acc_data = req_data[32*i +: 32];
        acc_last = req_last[i];
      end
    end
  end

  // Scheduler FSM
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    lock_d       = lock_q;
    flush_pend_d = flush_pend_q;
    flush_done_c = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (flush_req || flush_pend_q) begin
          state_d      = ST_FLUSH;
          flush_pend_d = 1'b0;
        end else if (acc) begin
          if (acc_last) begin
            rr_d = wrap_inc(arb_idx);
          end else begin
            lock_d  = arb_idx;
            state_d = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        if (flush_req) begin
          flush_pend_d = 1'b1;
        end
        if (acc && acc_last) begin
          rr_d         = wrap_inc(lock_q);
          state_d      = (flush_pend_q || flush_req) ? ST_FLUSH : ST_ARB;
          flush_pend_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        if ((occ_q == '0) && !dvld_q) begin
          flush_done_c = 1'b1;
          state_d      = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // Shadow occupancy: mirrors the streamer's 4-cycle drain cadence exactly.
  always_comb begin
    drain  = (occ_q != '0) && (dcnt_q == 2'd3);
    dcnt_d = (occ_q != '0) ? dcnt_q + 2'd1 : dcnt_q;
    occ_d  = occ_q + {{DEPTH_PWR{1'b0}}, dvld_q} - {{DEPTH_PWR{1'b0}}, drain};
    dout_d = acc ? acc_data : dout_q;
    dvld_d = acc;
    ovf_d  = ovf_q | strm_full | (occ_q == OCC_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ARB;
      rr_q         <= '0;
      lock_q       <= '0;
      flush_pend_q <= 1'b0;
      occ_q        <= '0;
      dcnt_q       <= '0;
      dout_q       <= '0;
      dvld_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      lock_q       <= lock_d;
      flush_pend_q <= flush_pend_d;
      occ_q        <= occ_d;
      dcnt_q       <= dcnt_d;
      dout_q       <= dout_d;
      dvld_q       <= dvld_d;
      ovf_q        <= ovf_d;
    end
  end

  assign out_din       = dout_q;
  assign out_din_valid = dvld_q;
  assign occ           = occ_q;
  assign overflow_err  = ovf_q;
  assign flush_done    = flush_done_c;

`ifdef PISO_STREAM_SCHED_BYTE_CNT_EN
  logic [31:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] lfb_q, lfb_d;

  // flush_done captures the running count, then the count restarts.
  always_comb begin
    lfb_d      = flush_done_c ? byte_cnt_q : lfb_q;
    byte_cnt_d = byte_cnt_q;
    if (flush_done_c) begin
      byte_cnt_d = '0;
    end else if (dvld_q) begin
      byte_cnt_d = byte_cnt_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      lfb_q      <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      lfb_q      <= lfb_d;
    end
  end

  assign byte_cnt         = byte_cnt_q;
  assign last_frame_bytes = lfb_q;
`endif

endmodule

// File: tb/tb_piso_stream_sched.sv
module tb_piso_stream_sched;

  localparam int unsigned NREQ      = 3;
  localparam int unsigned DEPTH_PWR = 4;
  localparam int unsigned HEADROOM  = 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ*32-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic [NREQ-1:0]      req_ready;
  logic [31:0]          out_din;
  logic                 out_din_valid;
  logic                 strm_full = 1'b0;
  logic                 flush_req = 1'b0;
  logic                 flush_done;
  logic [DEPTH_PWR:0]   occ;
  logic                 overflow_err;
`ifdef PISO_STREAM_SCHED_BYTE_CNT_EN
  logic [31:0]          byte_cnt;
  logic [31:0]          last_frame_bytes;
`endif

  always #5 clk = ~clk;

  piso_stream_sched #(
    .NREQ(NREQ),
    .DEPTH_PWR(DEPTH_PWR),
    .HEADROOM(HEADROOM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_data(req_data),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_ready(req_ready),
    .out_din(out_din),
    .out_din_valid(out_din_valid),
    .strm_full(strm_full),
    .flush_req(flush_req),
    .flush_done(flush_done),
    .occ(occ),
`ifdef PISO_STREAM_SCHED_BYTE_CNT_EN
    .byte_cnt(byte_cnt),
    .last_frame_bytes(last_frame_bytes),
`endif
    .overflow_err(overflow_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge of the same cycle.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    nxt();
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    flush_req = 1'b0;
    strm_full = 1'b0;
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    logic        exp_rdy;
    logic        exp_prev;
    logic [31:0] cur_data;
    logic [31:0] prev_data;
    logic [31:0] exp_data;
    logic [2:0]  exp_g;
    logic [2:0]  prev_g;
    logic [DEPTH_PWR:0] max_occ;
    logic [2:0]  exp4 [11];
    int          w;

    // ---------------- Reset state ----------------
    do_reset();
    smp();
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_dvld", 32'(out_din_valid), 32'd0);
    chk("rst_din", out_din, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_fdone", 32'(flush_done), 32'd0);
    chk("rst_ovf", 32'(overflow_err), 32'd0);
`ifdef PISO_STREAM_SCHED_BYTE_CNT_EN
    chk("rst_bcnt", byte_cnt, 32'd0);
    chk("rst_lfb", last_frame_bytes, 32'd0);
`endif

    // ---------------- Single requester, back-pressure by occupancy ----------
    // Grants while (words issued - words drained) < 15. Drains land at
    // cycles 5,9,13,...: grants at cycles 0..18, then 22,26,30,...
    do_reset();
    cur_data  = 32'h1000_0000;
    req_data[31:0] = cur_data;
    req_valid = 3'b001;
    req_last  = 3'b001;
    exp_prev  = 1'b0;
    prev_data = '0;
    max_occ   = '0;
    for (int c = 0; c < 50; c++) begin
      smp();
      exp_rdy = (c <= 18) || (c >= 22 && ((c - 22) % 4 == 0));
      chk($sformatf("t2_ready_c%0d", c), 32'(req_ready), exp_rdy ? 32'd1 : 32'd0);
      chk($sformatf("t2_dvld_c%0d", c), 32'(out_din_valid), exp_prev ? 32'd1 : 32'd0);
      if (exp_prev) chk($sformatf("t2_din_c%0d", c), out_din, prev_data);
      if (occ > max_occ) max_occ = occ;
      exp_prev  = exp_rdy;
      prev_data = cur_data;
      nxt();
      if (exp_rdy) begin
        cur_data       = cur_data + 32'd1;
        req_data[31:0] = cur_data;
      end
    end
    chk("t2_max_occ", 32'(max_occ), 32'd15);
    chk("t2_ovf", 32'(overflow_err), 32'd0);

    // ---------------- Round robin with single-word packets ----------------
    do_reset();
    for (int i = 0; i < 3; i++) req_data[32*i +: 32] = 32'hB000_0000 + 32'(i);
    req_valid = 3'b111;
    req_last  = 3'b111;
    for (int c = 0; c < 9; c++) begin
      smp();
      exp_g = 3'b001 << (c % 3);
      chk($sformatf("t3_ready_c%0d", c), 32'(req_ready), 32'(exp_g));
      if (c > 0) chk($sformatf("t3_din_c%0d", c), out_din, 32'hB000_0000 + 32'((c - 1) % 3));
      nxt();
    end

    // ---------------- Locked 5-word packet from requester 1 ----------------
    // Requester 1 idles in cycle 3 mid-packet; nobody else may be granted.
    do_reset();
    exp4 = '{3'b001, 3'b010, 3'b010, 3'b000, 3'b010, 3'b010,
             3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
    w = 0;
    prev_g = 3'b000;
    prev_data = '0;
    req_data[31:0]  = 32'hC000_0000;
    req_data[95:64] = 32'hC200_0000;
    req_valid[0] = 1'b1;
    req_valid[2] = 1'b1;
    req_last[0]  = 1'b1;
    req_last[2]  = 1'b1;
    for (int c = 0; c < 11; c++) begin
      req_valid[1]    = (c != 3) && (w < 5);
      req_last[1]     = (w == 4);
      req_data[63:32] = 32'hC100_0000 + 32'(w);
      smp();
      chk($sformatf("t4_ready_c%0d", c), 32'(req_ready), 32'(exp4[c]));
      if (prev_g != 3'b000) chk($sformatf("t4_din_c%0d", c), out_din, prev_data);
      case (exp4[c])
        3'b001:  exp_data = 32'hC000_0000;
        3'b010:  exp_data = 32'hC100_0000 + 32'(w);
        3'b100:  exp_data = 32'hC200_0000;
        default: exp_data = '0;
      endcase
      prev_g    = exp4[c];
      prev_data = exp_data;
      if (exp4[c] == 3'b010) w++;
      nxt();
    end

    // ---------------- Flush during the 3rd word of a 5-word packet ---------
    // Words issued cycles 0..4 (visible 1..5); occ=4 at cycle 6, drains at
    // cycles 9,13,17,21 -> occ=0 at cycle 22, flush_done there, grant at 23.
    do_reset();
    w = 0;
    req_data[95:64] = 32'hE200_0000;
    req_valid[2] = 1'b1;
    req_last[2]  = 1'b1;
    for (int c = 0; c < 25; c++) begin
      req_valid[0]   = (w < 5);
      req_last[0]    = (w == 4);
      req_data[31:0] = 32'hD000_0000 + 32'(w);
      flush_req      = (c == 2);
      smp();
      exp_g = (c <= 4) ? 3'b001 : (c >= 23) ? 3'b100 : 3'b000;
      chk($sformatf("t5_ready_c%0d", c), 32'(req_ready), 32'(exp_g));
      chk($sformatf("t5_fdone_c%0d", c), 32'(flush_done), (c == 22) ? 32'd1 : 32'd0);
      if (c == 6)  chk("t5_occ_c6", 32'(occ), 32'd4);
      if (c == 22) chk("t5_occ_c22", 32'(occ), 32'd0);
`ifdef PISO_STREAM_SCHED_BYTE_CNT_EN
      if (c == 22) chk("t5_bcnt_c22", byte_cnt, 32'd20);
      if (c == 23) chk("t5_bcnt_c23", byte_cnt, 32'd0);
      if (c == 23) chk("t5_lfb", last_frame_bytes, 32'd20);
`endif
      if (exp_g == 3'b001) w++;
      nxt();
    end
    flush_req = 1'b0;

    // ---------------- Sticky overflow from strm_full ----------------
    do_reset();
    smp();
    chk("t6_ovf_pre", 32'(overflow_err), 32'd0);
    nxt();
    strm_full = 1'b1;
    smp();
    chk("t6_ovf_same", 32'(overflow_err), 32'd0);
    nxt();
    strm_full = 1'b0;
    smp();
    chk("t6_ovf_set", 32'(overflow_err), 32'd1);
    repeat (5) nxt();
    smp();
    chk("t6_ovf_hold", 32'(overflow_err), 32'd1);

    // ---------------- Reset mid-packet with occ=7 ----------------
    do_reset();
    smp();
    chk("t7_ovf_clr", 32'(overflow_err), 32'd0);
    req_data[63:32] = 32'hF100_0000;
    req_valid = 3'b010;
    req_last  = 3'b000;
    for (int c = 0; c < 9; c++) begin
      smp();
      chk($sformatf("t7_ready_c%0d", c), 32'(req_ready), 32'd2);
      nxt();
    end
    smp();
    chk("t7_occ7", 32'(occ), 32'd7);
    rst = 1'b1;
    nxt();
    rst       = 1'b0;
    req_valid = 3'b000;
    smp();
    chk("t7_occ_rst", 32'(occ), 32'd0);
    chk("t7_ready_rst", 32'(req_ready), 32'd0);
    chk("t7_dvld_rst", 32'(out_din_valid), 32'd0);
    nxt();
    req_valid = 3'b111;
    req_last  = 3'b111;
    smp();
    chk("t7_first_grant", 32'(req_ready), 32'd1);
    nxt();
    req_valid = 3'b000;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time bound so the bench never hangs.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
